// File: rtl/riscv_issue.sv
// Issue stage: 32x32 regfile, operand read, one-entry issue register (RISCV_ISSUE_BYPASS_EN = writeback forwarding).
// Latency: 1 cycle from fetch acceptance to opcode_valid_o.
// Backpressure: exec_stall_i holds the issue register; without bypass a writeback RAW match drops accept for one cycle.
module riscv_issue (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [57:0] fetch_instr_i,
  input  logic [31:0] fetch_opcode_i,
  input  logic [31:0] fetch_pc_i,
  output logic        fetch_accept_o,
  input  logic        branch_request_i,
  input  logic [4:0]  writeback_idx_i,
  input  logic        writeback_squash_i,
  input  logic [31:0] writeback_value_i,
  input  logic        exec_stall_i,
  output logic        opcode_valid_o,
  output logic [57:0] opcode_instr_o,
  output logic [31:0] opcode_opcode_o,
  output logic [31:0] opcode_pc_o,
  output logic [4:0]  opcode_rd_idx_o,
  output logic [4:0]  opcode_ra_idx_o,
  output logic [4:0]  opcode_rb_idx_o,
  output logic [31:0] opcode_ra_operand_o,
  output logic [31:0] opcode_rb_operand_o
);

  logic [31:0] regfile [32];
  logic [4:0]  rs1, rs2;
  logic        wb_en, ra_match, rb_match, hazard;
  logic [31:0] ra_rf, rb_rf, ra_val, rb_val;

  assign rs1   = fetch_opcode_i[19:15];
  assign rs2   = fetch_opcode_i[24:20];
  assign wb_en = !writeback_squash_i && (writeback_idx_i != 5'd0);

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (wb_en) begin
      regfile[writeback_idx_i] <= writeback_value_i;
    end
  end

  assign ra_rf    = (rs1 == 5'd0) ? 32'd0 : regfile[rs1];
  assign rb_rf    = (rs2 == 5'd0) ? 32'd0 : regfile[rs2];
  assign ra_match = wb_en && (writeback_idx_i == rs1);
  assign rb_match = wb_en && (writeback_idx_i == rs2);

`ifdef RISCV_ISSUE_BYPASS_EN
  assign ra_val = ra_match ? writeback_value_i : ra_rf;
  assign rb_val = rb_match ? writeback_value_i : rb_rf;
  assign hazard = 1'b0;
`else
  // Hold fetch until the writeback has landed in the regfile.
  assign ra_val = ra_rf;
  assign rb_val = rb_rf;
  assign hazard = fetch_valid_i && (ra_match || rb_match);
`endif

  // Accept is independent of branch_request_i: a flushed instruction is consumed and dropped.
  assign fetch_accept_o = !exec_stall_i && !hazard;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      opcode_valid_o      <= 1'b0;
      opcode_instr_o      <= '0;
      opcode_opcode_o     <= '0;
      opcode_pc_o         <= '0;
      opcode_rd_idx_o     <= '0;
      opcode_ra_idx_o     <= '0;
      opcode_rb_idx_o     <= '0;
      opcode_ra_operand_o <= '0;
      opcode_rb_operand_o <= '0;
    end else if (branch_request_i) begin
      opcode_valid_o <= 1'b0;
    end else if (exec_stall_i) begin
      opcode_valid_o <= opcode_valid_o;
    end else if (fetch_valid_i && fetch_accept_o) begin
      opcode_valid_o      <= 1'b1;
      opcode_instr_o      <= fetch_instr_i;
      opcode_opcode_o     <= fetch_opcode_i;
      opcode_pc_o         <= fetch_pc_i;
      opcode_rd_idx_o     <= fetch_opcode_i[11:7];
      opcode_ra_idx_o     <= rs1;
      opcode_rb_idx_o     <= rs2;
      opcode_ra_operand_o <= ra_val;
      opcode_rb_operand_o <= rb_val;
    end else begin
      opcode_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_issue.sv
// Directed bench for riscv_issue: reset, issue, RAW handling, flush, stall, x0, async reset.
module tb_riscv_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [57:0] fetch_instr = '0;
  logic [31:0] fetch_opcode = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_accept;
  logic        branch_request = 1'b0;
  logic [4:0]  wb_idx = '0;
  logic        wb_squash = 1'b1;
  logic [31:0] wb_value = '0;
  logic        exec_stall = 1'b0;
  logic        opcode_valid;
  logic [57:0] opcode_instr;
  logic [31:0] opcode_opcode, opcode_pc, ra_operand, rb_operand;
  logic [4:0]  rd_idx, ra_idx, rb_idx;

  int total = 0;
  int bad = 0;

  localparam logic [57:0] INST_ADDI = 58'h1 << 10;
  localparam logic [57:0] INST_ADD  = 58'h1 << 3;
  localparam logic [31:0] OP_ADDI_X1_X0_5 = 32'h0050_0093;
  localparam logic [31:0] OP_ADD_X2_X1_X1 = 32'h0010_8133;
  localparam logic [31:0] OP_ADDI_X3_X1_7 = 32'h0070_8193;
  localparam logic [31:0] OP_ADD_X4_X0_X0 = 32'h0000_0233;

  always #5 clk = ~clk;

  riscv_issue dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .fetch_valid_i       (fetch_valid),
    .fetch_instr_i       (fetch_instr),
    .fetch_opcode_i      (fetch_opcode),
    .fetch_pc_i          (fetch_pc),
    .fetch_accept_o      (fetch_accept),
    .branch_request_i    (branch_request),
    .writeback_idx_i     (wb_idx),
    .writeback_squash_i  (wb_squash),
    .writeback_value_i   (wb_value),
    .exec_stall_i        (exec_stall),
    .opcode_valid_o      (opcode_valid),
    .opcode_instr_o      (opcode_instr),
    .opcode_opcode_o     (opcode_opcode),
    .opcode_pc_o         (opcode_pc),
    .opcode_rd_idx_o     (rd_idx),
    .opcode_ra_idx_o     (ra_idx),
    .opcode_rb_idx_o     (rb_idx),
    .opcode_ra_operand_o (ra_operand),
    .opcode_rb_operand_o (rb_operand)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (opcode_valid !== 1'b0 || opcode_pc !== 32'h0 || opcode_instr !== 58'h0 || opcode_opcode !== 32'h0) begin
      bad++;
      $display("FAIL reset_ctrl valid=%b pc=%h instr=%h op=%h, required all zero", opcode_valid, opcode_pc, opcode_instr, opcode_opcode);
    end
    total++;
    if (rd_idx !== 5'd0 || ra_idx !== 5'd0 || rb_idx !== 5'd0 || ra_operand !== 32'h0 || rb_operand !== 32'h0) begin
      bad++;
      $display("FAIL reset_operands rd=%0d ra=%0d rb=%0d ra_op=%h rb_op=%h, required all zero", rd_idx, ra_idx, rb_idx, ra_operand, rb_operand);
    end
    rst = 1'b1;
  endtask

  task automatic test_addi();
    fetch_valid = 1'b1; fetch_instr = INST_ADDI; fetch_opcode = OP_ADDI_X1_X0_5; fetch_pc = 32'h100;
    #1;
    total++;
    if (fetch_accept !== 1'b1) begin bad++; $display("FAIL addi_accept got=%b required=1", fetch_accept); end
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if (opcode_valid !== 1'b1 || opcode_pc !== 32'h100 || opcode_instr !== INST_ADDI || opcode_opcode !== OP_ADDI_X1_X0_5) begin
      bad++;
      $display("FAIL addi_issue valid=%b pc=%h instr=%h op=%h, required 1/100/%h/%h", opcode_valid, opcode_pc, opcode_instr, opcode_opcode, INST_ADDI, OP_ADDI_X1_X0_5);
    end
    total++;
    if (rd_idx !== 5'd1 || ra_idx !== 5'd0 || rb_idx !== 5'd5 || ra_operand !== 32'h0 || rb_operand !== 32'h0) begin
      bad++;
      $display("FAIL addi_fields rd=%0d ra=%0d rb=%0d ra_op=%h rb_op=%h, required 1/0/5/0/0", rd_idx, ra_idx, rb_idx, ra_operand, rb_operand);
    end
    @(negedge clk);
    total++;
    if (opcode_valid !== 1'b0 || opcode_pc !== 32'h100) begin
      bad++;
      $display("FAIL bubble_hold valid=%b pc=%h, required 0/100", opcode_valid, opcode_pc);
    end
  endtask

  task automatic test_back_to_back();
    wb_idx = 5'd1; wb_value = 32'd5; wb_squash = 1'b0;
    fetch_valid = 1'b1; fetch_instr = INST_ADD; fetch_opcode = OP_ADD_X2_X1_X1; fetch_pc = 32'h104;
    #1;
`ifdef RISCV_ISSUE_BYPASS_EN
    total++;
    if (fetch_accept !== 1'b1) begin bad++; $display("FAIL raw_accept got=%b required=1", fetch_accept); end
    @(negedge clk);
    wb_squash = 1'b1; fetch_valid = 1'b0;
`else
    total++;
    if (fetch_accept !== 1'b0) begin bad++; $display("FAIL raw_hazard_accept got=%b required=0", fetch_accept); end
    @(negedge clk);
    wb_squash = 1'b1;
    #1;
    total++;
    if (fetch_accept !== 1'b1 || opcode_valid !== 1'b0) begin
      bad++;
      $display("FAIL raw_retry accept=%b valid=%b, required 1/0", fetch_accept, opcode_valid);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
`endif
    total++;
    if (opcode_valid !== 1'b1 || opcode_pc !== 32'h104 || rd_idx !== 5'd2 || ra_operand !== 32'd5 || rb_operand !== 32'd5) begin
      bad++;
      $display("FAIL raw_issue valid=%b pc=%h rd=%0d ra_op=%h rb_op=%h, required 1/104/2/5/5", opcode_valid, opcode_pc, rd_idx, ra_operand, rb_operand);
    end
  endtask

  task automatic test_flush();
    fetch_valid = 1'b1; branch_request = 1'b1; fetch_instr = INST_ADDI; fetch_opcode = OP_ADDI_X3_X1_7; fetch_pc = 32'h200;
    #1;
    total++;
    if (fetch_accept !== 1'b1) begin bad++; $display("FAIL flush_accept got=%b required=1", fetch_accept); end
    @(negedge clk);
    branch_request = 1'b0; fetch_valid = 1'b0;
    total++;
    if (opcode_valid !== 1'b0 || opcode_pc !== 32'h104 || ra_operand !== 32'd5) begin
      bad++;
      $display("FAIL flush_drop valid=%b pc=%h ra_op=%h, required 0/104/5", opcode_valid, opcode_pc, ra_operand);
    end
  endtask

  task automatic test_x0();
    wb_idx = 5'd0; wb_value = 32'hDEAD_BEEF; wb_squash = 1'b0;
    fetch_valid = 1'b1; fetch_instr = INST_ADD; fetch_opcode = OP_ADD_X4_X0_X0; fetch_pc = 32'h400;
    #1;
    total++;
    if (fetch_accept !== 1'b1) begin bad++; $display("FAIL x0_accept got=%b required=1", fetch_accept); end
    @(negedge clk);
    wb_squash = 1'b1; fetch_pc = 32'h404;
    total++;
    if (opcode_valid !== 1'b1 || ra_operand !== 32'h0 || rb_operand !== 32'h0) begin
      bad++;
      $display("FAIL x0_same_cycle valid=%b ra_op=%h rb_op=%h, required 1/0/0", opcode_valid, ra_operand, rb_operand);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if (opcode_pc !== 32'h404 || ra_operand !== 32'h0 || rb_operand !== 32'h0) begin
      bad++;
      $display("FAIL x0_later pc=%h ra_op=%h rb_op=%h, required 404/0/0", opcode_pc, ra_operand, rb_operand);
    end
  endtask

  task automatic test_stall();
    fetch_valid = 1'b1; fetch_instr = INST_ADDI; fetch_opcode = OP_ADDI_X3_X1_7; fetch_pc = 32'h300;
    @(negedge clk);
    total++;
    if (opcode_valid !== 1'b1 || opcode_pc !== 32'h300 || ra_operand !== 32'd5 || rb_idx !== 5'd7) begin
      bad++;
      $display("FAIL stall_load valid=%b pc=%h ra_op=%h rb=%0d, required 1/300/5/7", opcode_valid, opcode_pc, ra_operand, rb_idx);
    end
    exec_stall = 1'b1; fetch_instr = INST_ADD; fetch_opcode = OP_ADD_X2_X1_X1; fetch_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (fetch_accept !== 1'b0) begin bad++; $display("FAIL stall_accept cycle=%0d got=%b required=0", i, fetch_accept); end
      @(negedge clk);
      total++;
      if (opcode_valid !== 1'b1 || opcode_pc !== 32'h300 || opcode_opcode !== OP_ADDI_X3_X1_7 || rd_idx !== 5'd3 || ra_operand !== 32'd5 || opcode_instr !== INST_ADDI) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d valid=%b pc=%h op=%h rd=%0d ra_op=%h, required 1/300/%h/3/5", i, opcode_valid, opcode_pc, opcode_opcode, rd_idx, ra_operand, OP_ADDI_X3_X1_7);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (opcode_valid !== 1'b0 || opcode_pc !== 32'h0 || opcode_opcode !== 32'h0 || ra_operand !== 32'h0 || rd_idx !== 5'd0) begin
      bad++;
      $display("FAIL async_reset valid=%b pc=%h op=%h ra_op=%h rd=%0d, required all zero", opcode_valid, opcode_pc, opcode_opcode, ra_operand, rd_idx);
    end
    exec_stall = 1'b0; fetch_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fetch_valid = 1'b1; fetch_instr = INST_ADD; fetch_opcode = OP_ADD_X2_X1_X1; fetch_pc = 32'h500;
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if (opcode_valid !== 1'b1 || opcode_pc !== 32'h500 || ra_operand !== 32'h0 || rb_operand !== 32'h0) begin
      bad++;
      $display("FAIL post_reset_regfile valid=%b pc=%h ra_op=%h rb_op=%h, required 1/500/0/0", opcode_valid, opcode_pc, ra_operand, rb_operand);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_flush();
    test_x0();
    test_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_issue.md
RISCV_ISSUE -- requirements
Module: riscv_issue

Interface
REQ-001 SHALL: clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  in  1  reset; asynchronous assert, active-low.
REQ-003 SHALL: fetch_valid_i  in  1  decoded instruction present.
REQ-004 SHALL: fetch_instr_i  in  58  one-hot instruction enum (ENUM_INST_* bit positions).
REQ-005 SHALL: fetch_opcode_i  in  32  raw instruction word.
REQ-006 SHALL: fetch_pc_i  in  32  instruction PC.
REQ-007 SHALL: fetch_accept_o  out  1  instruction taken this cycle.
REQ-008 SHALL: branch_request_i  in  1  taken branch/jump from exec; flush.
REQ-009 SHALL: writeback_idx_i  in  5  exec destination register.
REQ-010 SHALL: writeback_squash_i  in  1  1 = no write.
REQ-011 SHALL: writeback_value_i  in  32  exec result.
REQ-012 SHALL: exec_stall_i  in  1  exec cannot take new instruction.
REQ-013 SHALL: opcode_valid_o  out  1  issue register valid.
REQ-014 SHALL: opcode_instr_o  out  58  registered fetch_instr_i.
REQ-015 SHALL: opcode_opcode_o  out  32  registered fetch_opcode_i.
REQ-016 SHALL: opcode_pc_o  out  32  registered fetch_pc_i.
REQ-017 SHALL: opcode_rd_idx_o  out  5  registered opcode[11:7].
REQ-018 SHALL: opcode_ra_idx_o  out  5  registered opcode[19:15].
REQ-019 SHALL: opcode_rb_idx_o  out  5  registered opcode[24:20].
REQ-020 SHALL: opcode_ra_operand_o  out  32  registered rs1 value.
REQ-021 SHALL: opcode_rb_operand_o  out  32  registered rs2 value.

Function
REQ-022 SHALL: hold a 32x32 register file; x0 reads 0 and is never written.
REQ-023 SHALL: write regfile[writeback_idx_i] <= writeback_value_i at the clock edge when writeback_squash_i=0 and writeback_idx_i!=0.
REQ-024 SHALL: read rs1/rs2 combinationally from fetch_opcode_i[19:15]/[24:20]; results feed the issue register.
REQ-025 SHALL: drive fetch_accept_o = !exec_stall_i && !hazard, where hazard is defined in REQ-040/041.
REQ-026 SHALL: update the issue register by priority: branch_request_i=1 -> valid<=0; else exec_stall_i=1 -> hold all fields; else fetch_valid_i && fetch_accept_o -> load all fields, valid<=1; else valid<=0 (bubble).
REQ-027 SHALL: never let a flushed instruction raise fetch_accept_o semantics; fetch must see accept even when flushed, and the instruction is discarded.
REQ-028 SHALL: add 1-cycle latency from fetch acceptance to opcode_valid_o.
REQ-029 SHALL: keep output fields unchanged when valid<=0 is loaded; only valid clears.
REQ-030 SHALL: resolve a same-edge write and read of the same register per REQ-040/041; no stale operand ever issued.

Reset
REQ-031 SHALL: while rst_i=0, hold opcode_valid_o=0, all opcode_* fields=0, and all 32 registers=0.
REQ-032 SHALL: on reset mid-stall or mid-flush, discard all pending state; first edge after release behaves as REQ-026.

Configuration
REQ-040 SHALL: with RISCV_ISSUE_BYPASS_EN defined, forward writeback_value_i into the operand when writeback_squash_i=0, writeback_idx_i!=0, and writeback_idx_i equals rs1/rs2; hazard=0 always.
REQ-041 SHALL: without RISCV_ISSUE_BYPASS_EN, set hazard=1 under the same match condition while fetch_valid_i=1, which drops fetch_accept_o for exactly one cycle; the operand is read from the regfile on the next cycle.

Verification
REQ-050 SHALL: reset release, ADDI x1,x0,5 -> opcode_valid_o=1 next cycle, ra_operand=0, pc echoed.
REQ-051 SHALL: writeback x1=5, then ADD x2,x1,x1 back-to-back -> bypass build: ra/rb=5, no stall; non-bypass build: accept low 1 cycle, then ra/rb=5.
REQ-052 SHALL: branch_request_i=1 with fetch_valid_i=1 -> opcode_valid_o=0 next cycle; instruction not issued.
REQ-053 SHALL: exec_stall_i=1 for 3 cycles -> fetch_accept_o=0 and all opcode_* outputs held stable.
REQ-054 SHALL: writeback to x0 with value 0xDEADBEEF -> later read of x0 gives 0.
REQ-055 SHALL: assert rst_i low mid-stall with valid=1 -> outputs 0 immediately, asynchronously.
